// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-select width, bitwise op codes and output-register states.
package alu_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND    = 3'b000;
    localparam logic [OP_W-1:0] OP_OR     = 3'b001;
    localparam logic [OP_W-1:0] OP_XOR    = 3'b010;
    localparam logic [OP_W-1:0] OP_NAND   = 3'b011;
    localparam logic [OP_W-1:0] OP_NOR    = 3'b100;
    localparam logic [OP_W-1:0] OP_XNOR   = 3'b101;
    localparam logic [OP_W-1:0] OP_NOT_A  = 3'b110;
    localparam logic [OP_W-1:0] OP_PASS_A = 3'b111;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/logic_op_core.sv
// Combinational bitwise operation core: (op, a, b) -> WIDTH-bit result.
module logic_op_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Select the bitwise function; NOT/PASS ignore b.
    always_comb begin
        y = {WIDTH{1'b0}};
        case (op)
            OP_AND:    y = a & b;
            OP_OR:     y = a | b;
            OP_XOR:    y = a ^ b;
            OP_NAND:   y = ~(a & b);
            OP_NOR:    y = ~(a | b);
            OP_XNOR:   y = ~(a ^ b);
            OP_NOT_A:  y = ~a;
            OP_PASS_A: y = a;
            default:   y = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/bitwise_logic_unit.sv
// Registered bitwise logic unit with a one-entry valid/ready output register,
// a chaining accumulator and an accepted-transaction counter.
module bitwise_logic_unit
    import alu_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter int OUT_WIDTH = 2 * WIDTH,
    parameter int COUNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OP_W-1:0]      op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 acc_sel,
    input  logic                 acc_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] result,
    output logic                 out_zero,
    output logic [WIDTH-1:0]     acc,
    output logic [COUNT_W-1:0]   op_count
);

    out_state_e         state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic               accept_s;
    logic [WIDTH-1:0]   operand_b_s;
    logic [WIDTH-1:0]   op_res_s;

    assign in_ready = (state_q == ST_EMPTY) | out_ready;
    assign accept_s = in_valid & in_ready;

    // Clear wins over the accumulator so the op sees 0 as operand B.
    assign operand_b_s = acc_sel ? (acc_clr ? {WIDTH{1'b0}} : acc_q) : b;

    logic_op_core #(.WIDTH(WIDTH)) u_core (
        .op (op),
        .a  (a),
        .b  (operand_b_s),
        .y  (op_res_s)
    );

    // Next-state: output register handshake, accumulator and counter updates.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        acc_d    = acc_q;
        count_d  = count_q;
        if (accept_s) begin
            result_d = op_res_s;
            zero_d   = (op_res_s == {WIDTH{1'b0}});
            acc_d    = op_res_s;
            count_d  = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d  = count_q;
        end
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) state_d = ST_FULL;
                else          state_d = ST_EMPTY;
            end
            ST_FULL: begin
                if (accept_s)       state_d = ST_FULL;
                else if (out_ready) state_d = ST_EMPTY;
                else                state_d = ST_FULL;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            result_q <= {WIDTH{1'b0}};
            zero_q   <= 1'b0;
            acc_q    <= {WIDTH{1'b0}};
            count_q  <= {COUNT_W{1'b0}};
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign result    = {{(OUT_WIDTH-WIDTH){1'b0}}, result_q};
    assign out_zero  = zero_q;
    assign acc       = acc_q;
    assign op_count  = count_q;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Directed self-checking bench for bitwise_logic_unit (WIDTH=3), with a second
// COUNT_W=2 instance sharing the inputs to exercise counter wrap.
module tb_bitwise_logic_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, out_ready, acc_sel, acc_clr;
    logic [2:0] op, a, b;

    logic       in_ready, out_valid, out_zero;
    logic [5:0] result;
    logic [2:0] acc;
    logic [7:0] op_count;

    logic       in_ready2, out_valid2, out_zero2;
    logic [5:0] result2;
    logic [2:0] acc2;
    logic [1:0] op_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bitwise_logic_unit #(.WIDTH(3), .OUT_WIDTH(6), .COUNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .acc_sel(acc_sel), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .out_zero(out_zero), .acc(acc), .op_count(op_count)
    );

    bitwise_logic_unit #(.WIDTH(3), .OUT_WIDTH(6), .COUNT_W(2)) dut_w2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .op(op), .a(a), .b(b), .acc_sel(acc_sel), .acc_clr(acc_clr),
        .out_valid(out_valid2), .out_ready(out_ready), .result(result2),
        .out_zero(out_zero2), .acc(acc2), .op_count(op_count2)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; acc_sel = 1'b0; acc_clr = 1'b0;
        op = 3'b000; a = 3'b000; b = 3'b000;
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (result !== 6'b000000) begin errors++; $display("FAIL reset_result got %b exp 000000", result); end
        checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL reset_out_zero got %b exp 0", out_zero); end
        checks++; if (acc !== 3'b000) begin errors++; $display("FAIL reset_acc got %b exp 000", acc); end
        checks++; if (op_count !== 8'd0) begin errors++; $display("FAIL reset_op_count got %0d exp 0", op_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        op = 3'b001; a = 3'b101; b = 3'b011; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got %b exp 1", out_valid); end
        checks++; if (result !== 6'b000111) begin errors++; $display("FAIL basic_result got %b exp 000111", result); end
        checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL basic_out_zero got %b exp 0", out_zero); end
        checks++; if (op_count !== 8'd1) begin errors++; $display("FAIL basic_op_count got %0d exp 1", op_count); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_all_ops();
        logic [2:0] exp_tab [8];
        exp_tab = '{3'b010, 3'b111, 3'b101, 3'b101, 3'b000, 3'b010, 3'b001, 3'b110};
        a = 3'b110; b = 3'b011; out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            step();
            checks++;
            if (result !== {3'b000, exp_tab[i]} || out_valid !== 1'b1)
                begin errors++; $display("FAIL op%0d_result got %b v=%b exp %b v=1", i, result, out_valid, {3'b000, exp_tab[i]}); end
            checks++;
            if (out_zero !== (exp_tab[i] == 3'b000))
                begin errors++; $display("FAIL op%0d_out_zero got %b exp %b", i, out_zero, (exp_tab[i] == 3'b000)); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (op_count !== 8'd9) begin errors++; $display("FAIL allops_op_count got %0d exp 9", op_count); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0; in_valid = 1'b1; op = 3'b000; a = 3'b111; b = 3'b101;
        step();
        op = 3'b010; a = 3'b011; b = 3'b001;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (result !== 6'b000101 || out_valid !== 1'b1 || in_ready !== 1'b0)
                begin errors++; $display("FAIL hold%0d got r=%b v=%b rdy=%b exp r=000101 v=1 rdy=0", i, result, out_valid, in_ready); end
            step();
        end
        checks++; if (op_count !== 8'd10) begin errors++; $display("FAIL hold_op_count got %0d exp 10", op_count); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b exp 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (result !== 6'b000010 || out_valid !== 1'b1) begin errors++; $display("FAIL reload_result got %b v=%b exp 000010 v=1", result, out_valid); end
        checks++; if (op_count !== 8'd11) begin errors++; $display("FAIL reload_op_count got %0d exp 11", op_count); end
        step();
        checks++; if (out_valid !== 1'b0 || op_count !== 8'd11) begin errors++; $display("FAIL no_dup got v=%b cnt=%0d exp v=0 cnt=11", out_valid, op_count); end
    endtask

    task automatic test_accumulate();
        out_ready = 1'b1; in_valid = 1'b1; acc_sel = 1'b1; acc_clr = 1'b1;
        op = 3'b001; a = 3'b001; b = 3'b111;
        step();
        checks++; if (acc !== 3'b001 || result !== 6'b000001) begin errors++; $display("FAIL acc_clear got acc=%b r=%b exp acc=001 r=000001", acc, result); end
        acc_clr = 1'b0; a = 3'b010;
        step();
        checks++; if (acc !== 3'b011) begin errors++; $display("FAIL acc_chain1 got %b exp 011", acc); end
        a = 3'b100;
        step();
        checks++; if (acc !== 3'b111 || result !== 6'b000111) begin errors++; $display("FAIL acc_chain2 got acc=%b r=%b exp acc=111 r=000111", acc, result); end
        in_valid = 1'b0; acc_clr = 1'b1;
        step(); step();
        checks++; if (acc !== 3'b111) begin errors++; $display("FAIL acc_clr_no_accept got %b exp 111", acc); end
        acc_sel = 1'b0; acc_clr = 1'b0;
        checks++; if (op_count !== 8'd14) begin errors++; $display("FAIL acc_op_count got %0d exp 14", op_count); end
    endtask

    task automatic test_counter_wrap();
        logic [1:0] exp2 [5];
        exp2 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rst = 1'b1; step(); rst = 1'b0;
        out_ready = 1'b1; in_valid = 1'b1; op = 3'b111; a = 3'b010; b = 3'b000;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (op_count2 !== exp2[i] || op_count !== 8'(i + 1))
                begin errors++; $display("FAIL wrap%0d got w2=%0d w8=%0d exp w2=%0d w8=%0d", i, op_count2, op_count, exp2[i], i + 1); end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1; acc_sel = 1'b0; op = 3'b111; a = 3'b101;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || acc !== 3'b101) begin errors++; $display("FAIL premid got v=%b acc=%b exp v=1 acc=101", out_valid, acc); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || acc !== 3'b000 || op_count !== 8'd0 || result !== 6'b000000)
            begin errors++; $display("FAIL async_reset got v=%b acc=%b cnt=%0d r=%b exp 0", out_valid, acc, op_count, result); end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_ops();
        test_back_to_back();
        test_accumulate();
        test_counter_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
